// File: rtl/serial_tx_arbiter.sv
// Four-channel round-robin arbiter feeding one serial line.
// Each frame is a 2-bit channel id followed by DATA_W payload bits, MSB first, then one gap cycle.
module serial_tx_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [3:0]        ack,
    output logic              serOut,
    output logic              serValid,
    output logic              busy
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(DATA_W + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;
    logic [3:0]         ack_q, ack_d;

    logic [DATA_W-1:0]  din_arr [4];
    logic               win_valid;
    logic [1:0]         win_id;
    logic [1:0]         cand;

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;

    // Search starts just after the last granted channel and wraps around.
    always_comb begin
        win_valid = 1'b0;
        win_id    = last_q;
        cand      = '0;
        for (int off = 1; off <= 4; off++) begin
            cand = last_q + 2'(off);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    shift_d        = {win_id, din_arr[win_id]};
                    last_d         = win_id;
                    cnt_d          = '0;
                    ack_d[win_id]  = 1'b1;
                    state_d        = HEADER;
                end
            end
            HEADER: begin
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W + 1)) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // lastGrant resets to 3 so channel 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
        end
    end

    assign ack      = ack_q;
    assign serValid = (state_q == HEADER) || (state_q == PAYLOAD);
    assign serOut   = serValid & shift_q[FRAME_W-1];
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: frame-schedule reference model compared every cycle,
// plus directed scenarios with hand-computed serial patterns and grant orders.
module tb_serial_tx_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = '0;
    logic [DW-1:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;
    logic [3:0]    ack;
    logic          serOut, serValid, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_tx_arbiter #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .ack(ack), .serOut(serOut), .serValid(serValid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ack;
        logic       ser;
        logic       val;
        logic       busy;
    } exp_t;

    exp_t exp_cur = '0;
    exp_t sched[$];
    int   last_grant = 3;
    int   log_ch[$];
    int   log_cyc[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] din_of(int ch);
        case (ch)
            0: return din0;
            1: return din1;
            2: return din2;
            default: return din3;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: on a grant, the whole frame's per-cycle outputs are scheduled.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            sched.delete();
            exp_cur    = '0;
            last_grant = 3;
        end else if (sched.size() > 0) begin
            exp_cur = sched.pop_front();
        end else if (!exp_cur.busy && req != 4'b0) begin
            int w;
            logic [DW+1:0] word;
            exp_t e;
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && req[(last_grant + k) % 4]) w = (last_grant + k) % 4;
            last_grant = w;
            word = {2'(w), din_of(w)};
            for (int i = 0; i < DW + 2; i++) begin
                e.ack  = (i == 0) ? (4'b0001 << w) : 4'b0000;
                e.ser  = word[DW + 1 - i];
                e.val  = 1'b1;
                e.busy = 1'b1;
                sched.push_back(e);
            end
            e = '0;
            e.busy = 1'b1;
            sched.push_back(e);
            exp_cur = sched.pop_front();
        end else begin
            exp_cur = '0;
        end
    end

    // Per-cycle compare plus grant log.
    initial forever begin
        @(negedge clk);
        chk("cycle_outputs", 32'({ack, serOut, serValid, busy}), 32'(exp_cur));
        if (ack != 4'b0) begin
            for (int c = 0; c < 4; c++)
                if (ack[c]) begin
                    log_ch.push_back(c);
                    log_cyc.push_back(cyc);
                    $display("frame ch=%0d cycle=%0d", c, cyc);
                end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_ch.delete();
        log_cyc.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    initial begin
        logic [9:0] bits;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ack", 32'(ack), 32'(0));
        chk("reset_busy", 32'({serOut, serValid, busy}), 32'(0));
        rst = 1'b0;

        // Single request, A5 on channel 0
        do_reset();
        din0 = 8'hA5;
        req  = 4'b0001;
        @(negedge clk);
        req  = 4'b0000;
        bits = 10'b00_1010_0101;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("a5_ack%0d", i), 32'(ack), (i == 0) ? 32'h1 : 32'h0);
            chk($sformatf("a5_bit%0d", i), 32'({serOut, serValid}), 32'({bits[9 - i], 1'b1}));
            @(negedge clk);
        end
        chk("a5_gap", 32'({serOut, serValid, busy}), 32'b001);
        @(negedge clk);
        chk("a5_idle", 32'(busy), 32'(0));

        // Round-robin with all channels requesting from reset
        rst = 1'b1;
        req = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_ch.delete();
        log_cyc.delete();
        repeat (5 * 12 + 4) @(negedge clk);
        chk("rr_count", 32'(log_ch.size() >= 5), 32'(1));
        if (log_ch.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr_ch%0d", i), 32'(log_ch[i]), 32'(i % 4));
            for (int i = 0; i < 4; i++)
                chk($sformatf("rr_gap%0d", i), 32'(log_cyc[i + 1] - log_cyc[i]), 32'(12));
        end
        req = 4'b0;
        wait_idle();

        // Wrap priority: after ch2, req 0101 grants ch0
        do_reset();
        din2 = 8'($urandom);
        req  = 4'b0100;
        @(negedge clk);
        req  = 4'b0;
        wait_idle();
        req  = 4'b0101;
        @(negedge clk);
        req  = 4'b0;
        chk("wrap_ack", 32'(ack), 32'h1);
        chk("wrap_hdr0", 32'({serOut, serValid}), 32'b01);
        @(negedge clk);
        chk("wrap_hdr1", 32'({serOut, serValid}), 32'b01);
        wait_idle();

        // Mid-frame reset during payload bit 4
        do_reset();
        din0 = 8'($urandom);
        req  = 4'b0001;
        @(negedge clk);
        req  = 4'b0;
        repeat (6) @(negedge clk);
        chk("mrst_inframe", 32'(serValid), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("mrst_now", 32'({ack, serValid, busy}), 32'(0));
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b0100;
        @(negedge clk);
        req  = 4'b0;
        chk("mrst_ack2", 32'(ack), 32'h4);
        chk("mrst_hdr", 32'({serOut, serValid}), 32'b11);
        wait_idle();

        // Data hold: din1 changes mid-payload
        do_reset();
        din1 = 8'h3C;
        req  = 4'b0010;
        @(negedge clk);
        req  = 4'b0;
        bits = 10'b01_0011_1100;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_bit%0d", i), 32'({serOut, serValid}), 32'({bits[9 - i], 1'b1}));
            if (i == 3) din1 = 8'hFF;
            @(negedge clk);
        end
        wait_idle();

        // Randomized traffic with occasional asynchronous resets
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din0 = 8'($urandom);
            din1 = 8'($urandom);
            din2 = 8'($urandom);
            din3 = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        req = 4'b0;
        repeat (15) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter: DATA_W, default 8, payload bits per frame.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: req  input  4  per-channel transmit request, bit i = channel i.
REQ-006 Port: din0..din3  input  DATA_W each  payload of channel 0..3, held stable while its req is high.
REQ-007 Port: ack  output  4  one-hot, one-cycle pulse: the frame of channel i has been captured.
REQ-008 Port: serOut  output  1  shared serial data line.
REQ-009 Port: serValid  output  1  high while serOut carries frame bits.
REQ-010 Port: busy  output  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, HEADER, PAYLOAD and GAP.
REQ-012 IDLE with req==0 SHALL stay in IDLE.
REQ-013 IDLE with req!=0 SHALL select a winner by round-robin:
- search starts at channel (lastGrant+1) mod 4 and wraps;
- the first asserted channel wins.
REQ-014 On the selecting edge, the block SHALL:
- load the shift register with {winnerId[1:0], dinWinner}, MSB first;
- set lastGrant to the winner;
- clear the bit counter;
- enter HEADER.
REQ-015 ack SHALL be registered: only the winner's bit is high, for exactly the first HEADER cycle.
REQ-016 HEADER SHALL last 2 cycles, then PAYLOAD SHALL last DATA_W cycles.
- One bit shifts out per cycle.
- serOut = shift register MSB.
- serValid = 1 throughout both states.
REQ-017 The bit counter SHALL count 0..DATA_W+1 across HEADER and PAYLOAD.
- HEADER->PAYLOAD when count==1.
- PAYLOAD->GAP when count==DATA_W+1.
- The counter width SHALL hold DATA_W+1.
REQ-018 GAP SHALL last exactly 1 cycle (serValid=0, serOut=0), then the FSM SHALL return to IDLE.
REQ-019 Latency: for a request sampled at edge k:
- ack is high in cycle k+1;
- serValid is high in cycles k+1..k+DATA_W+2;
- GAP is cycle k+DATA_W+3;
- IDLE is cycle k+DATA_W+4.
- The minimum spacing between frame starts is DATA_W+4 cycles.
REQ-020 req changes and din changes during HEADER, PAYLOAD or GAP SHALL NOT affect the frame in flight.
REQ-021 In IDLE, serValid=0 and serOut=0.
REQ-022 Simultaneous requests SHALL grant one channel per frame. A channel still requesting after its ack SHALL be granted again only after every other requesting channel, per the rotation.
REQ-023 A requester SHALL drop req within DATA_W+2 cycles after ack, or it is treated as a new request.
REQ-024 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-025 rst high SHALL immediately force the following, regardless of clk:
- state=IDLE;
- ack=0, serOut=0, serValid=0, busy=0;
- bit counter=0, shift register=0;
- lastGrant=3, so that channel 0 has first priority.
REQ-026 rst asserted mid-frame SHALL abort the frame with no further ack or serValid; the aborted channel is not credited as granted.
REQ-027 After rst deasserts, the first rising edge SHALL behave as IDLE.

Verification
REQ-028 Single request, DATA_W=8:
- Stimulus: req=0001, din0=8'hA5 sampled at edge k.
- Response: ack=0001 in cycle k+1 only.
- serOut over cycles k+1..k+10 = 0,0,1,0,1,0,0,1,0,1 with serValid=1.
- GAP at k+11.
REQ-029 Round-robin: req=1111 held continuously from reset. Grant order SHALL be ch0, ch1, ch2, ch3, ch0; frame starts are 12 cycles apart.
REQ-030 Wrap priority:
- Stimulus: after a ch2 frame, req=0101.
- Response: ch0 granted (search order 3,0,1,2); header bits = 0,0.
REQ-031 Mid-frame reset:
- Stimulus: rst pulsed during PAYLOAD bit 4.
- Response: serValid=0, busy=0 immediately; next req=0100 yields a ch2 frame with ack in the following cycle.
REQ-032 Data hold:
- Stimulus: din1 changed from 8'h3C to 8'hFF during the ch1 PAYLOAD.
- Response: serial payload still equals 8'h3C; header bits = 0,1.
